i2s_sample_sync: RTL

Input conditioning stage between the I2S receive codec and `three_band_eq`. It takes the codec's 32-bit sample word and one-cycle valid strobe, tags each word as left or right from `l_r_clk`, converts it from 24-bit to the 16-bit signed format the EQ consumes, and pairs left and right into a stereo frame. Frames are buffered in a small FIFO behind a valid/ready handshake, so the EQ never sees a half-updated or torn frame.

---
 rtl/i2s_sample_sync.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/i2s_sample_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2s_sample_sync
// Purpose  : Tags I2S receive words as left/right, converts 24-bit samples to
//            16-bit signed, pairs them into stereo frames and buffers the
//            frames in a small FIFO behind a valid/ready handshake.
// Options  : I2S_SAMPLE_SYNC_ROUND_EN - round half-up with saturation instead
//            of plain truncation.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_sample_sync #(
  parameter int DEPTH   = 4,
  parameter int LEFT_WS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        l_r_clk,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  input  logic        out_ready,
  input  logic        clear,
  output logic [15:0] out_left,
  output logic [15:0] out_right,
  output logic        out_valid,
  output logic        overflow,
  output logic        slip
);

  localparam int         c_aw  = $clog2(DEPTH);
  localparam logic [c_aw:0] c_one = {{c_aw{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    WAIT_L = 1'b0,
    HAVE_L = 1'b1
  } state_t;

  state_t             r_state;
  logic [15:0]        r_left_hold;
  logic [31:0]        r_mem [DEPTH];
  logic [c_aw:0]      r_wr_ptr;
  logic [c_aw:0]      r_rd_ptr;
  logic [15:0]        r_out_left;
  logic [15:0]        r_out_right;
  logic               r_overflow;
  logic               r_slip;

  logic [15:0]        w_y;
  logic               w_is_left;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_write;
  logic               w_ovf_evt;
  logic               w_slip_evt;
  logic [31:0]        w_frame;
  logic [c_aw:0]      w_wr_next;
  logic [c_aw:0]      w_rd_next;
  logic               w_unused_bits;

  // Sample conversion from 24-bit signed to 16-bit signed.
`ifdef I2S_SAMPLE_SYNC_ROUND_EN
  logic [24:0] w_sum;
  logic [16:0] w_rnd;
  assign w_sum = {rx_data[23], rx_data[23:0]} + 25'h000080;
  assign w_rnd = w_sum[24:8];
  // A positive result with bit 15 set is above 32767; negatives cannot overflow.
  assign w_y   = (!w_rnd[16] && w_rnd[15]) ? 16'h7FFF : w_rnd[15:0];
  assign w_unused_bits = ^{rx_data[31:24], w_sum[7:0]};
`else
  assign w_y   = rx_data[23:8];
  assign w_unused_bits = ^{rx_data[31:24], rx_data[7:0]};
`endif

  assign w_is_left  = (l_r_clk == LEFT_WS[0]);
  assign w_push     = rx_valid && (r_state == HAVE_L) && !w_is_left;
  assign w_slip_evt = rx_valid && (((r_state == WAIT_L) && !w_is_left) ||
                                   ((r_state == HAVE_L) &&  w_is_left));
  assign w_frame    = {r_left_hold, w_y};

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_pop     = !w_empty && out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign w_write   = w_push && (!w_full || w_pop);
  assign w_ovf_evt = w_push && w_full && !w_pop;
  assign w_wr_next = w_write ? (r_wr_ptr + c_one) : r_wr_ptr;
  assign w_rd_next = w_pop   ? (r_rd_ptr + c_one) : r_rd_ptr;

  // Left/right pairing state machine with the held left sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= WAIT_L;
      r_left_hold <= 16'h0000;
    end else if (rx_valid) begin
      case (r_state)
        WAIT_L: begin
          if (w_is_left) begin
            r_left_hold <= w_y;
            r_state     <= HAVE_L;
          end
        end
        HAVE_L: begin
          if (w_is_left) begin
            r_left_hold <= w_y;
          end else begin
            r_state     <= WAIT_L;
          end
        end
        default: r_state <= WAIT_L;
      endcase
    end
  end

  // Frame storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (!reset && w_write) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= w_frame;
    end
  end

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
    end
  end

  // Registered head frame; it is refreshed only while the next state is
  // non-empty so the outputs hold their last value once the FIFO drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_left  <= 16'h0000;
      r_out_right <= 16'h0000;
    end else if (w_rd_next != w_wr_next) begin
      if (w_write && (w_rd_next == r_wr_ptr)) begin
        r_out_left  <= w_frame[31:16];
        r_out_right <= w_frame[15:0];
      end else begin
        r_out_left  <= r_mem[w_rd_next[c_aw-1:0]][31:16];
        r_out_right <= r_mem[w_rd_next[c_aw-1:0]][15:0];
      end
    end
  end

  // Sticky flags; a set event in the same cycle as clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_slip     <= 1'b0;
    end else begin
      if (w_ovf_evt)       r_overflow <= 1'b1;
      else if (clear)      r_overflow <= 1'b0;
      if (w_slip_evt)      r_slip     <= 1'b1;
      else if (clear)      r_slip     <= 1'b0;
    end
  end

  assign out_left  = r_out_left;
  assign out_right = r_out_right;
  assign out_valid = !w_empty;
  assign overflow  = r_overflow;
  assign slip      = r_slip;

endmodule
`default_nettype wire
